// File: rtl/axis_complex_framer_pkg.sv
// rtl/axis_complex_framer_pkg.sv - shared constants and state encoding for the complex framer
package axis_complex_framer_pkg;

  localparam logic RESET_ENABLE_ = 1'b0;
  localparam logic ENABLE        = 1'b1;
  localparam logic DISABLE       = 1'b0;
  localparam int   AXIS_TDATA_W  = 32;

  typedef enum logic {
    RUN = 1'b0,
    PAD = 1'b1
  } framer_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry (main + skid) AXIS output buffer; tuser present with AXIS_FRAMER_TUSER_EN
module axis_skid_buf
  import axis_complex_framer_pkg::*;
#(
  parameter int DATA_W = 2 * AXIS_TDATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
`ifdef AXIS_FRAMER_TUSER_EN
  input  logic              s_tuser,
`endif
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic              s_tready_next,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
`ifdef AXIS_FRAMER_TUSER_EN
  output logic              m_tuser,
`endif
  output logic              m_tvalid,
  input  logic              m_tready
);

`ifdef AXIS_FRAMER_TUSER_EN
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = DATA_W;
`endif

  logic [PW-1:0] s_pay;
  logic [PW-1:0] main_pay;
  logic [PW-1:0] skid_pay;
  logic          skid_valid;
  logic          skid_last;
  logic          main_load;
  logic          enq;
  logic          m_valid_n;
  logic          skid_valid_n;

`ifdef AXIS_FRAMER_TUSER_EN
  assign s_pay             = {s_tuser, s_tdata};
  assign {m_tuser, m_tdata} = main_pay;
`else
  assign s_pay   = s_tdata;
  assign m_tdata = main_pay;
`endif

  assign s_tready  = ~skid_valid;
  assign enq       = s_tvalid & ~skid_valid;
  // Main register may take a new beat when empty or being consumed this cycle.
  assign main_load = ~m_tvalid | m_tready;

  always_comb begin
    m_valid_n    = m_tvalid;
    skid_valid_n = skid_valid;
    if (main_load) begin
      if (skid_valid) begin
        m_valid_n    = 1'b1;
        skid_valid_n = 1'b0;
      end else begin
        m_valid_n = enq;
      end
    end else if (enq) begin
      skid_valid_n = 1'b1;
    end
  end

  assign s_tready_next = ~skid_valid_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RESET_ENABLE_) begin
      m_tvalid   <= DISABLE;
      m_tlast    <= DISABLE;
      skid_valid <= DISABLE;
      skid_last  <= DISABLE;
    end else begin
      m_tvalid   <= m_valid_n;
      skid_valid <= skid_valid_n;
      if (main_load && skid_valid) begin
        m_tlast <= skid_last;
      end else if (main_load && enq) begin
        m_tlast <= s_tlast;
      end
      if (!main_load && enq) begin
        skid_last <= s_tlast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (main_load && skid_valid) begin
      main_pay <= skid_pay;
    end else if (main_load && enq) begin
      main_pay <= s_pay;
    end
    if (!main_load && enq) begin
      skid_pay <= s_pay;
    end
  end

endmodule

// File: rtl/axis_complex_framer.sv
// rtl/axis_complex_framer.sv - real PCM to complex AXIS framer with flush zero-padding
// Optional m00_axis_tuser (start-of-frame) enabled by macro AXIS_FRAMER_TUSER_EN.
module axis_complex_framer
  import axis_complex_framer_pkg::*;
#(
  parameter int FRAME_LEN = 4096,
  parameter int DATA_W    = AXIS_TDATA_W
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic [DATA_W-1:0]     s00_axis_tdata,
  input  logic                  s00_axis_tvalid,
  output logic                  s00_axis_tready,
  input  logic                  flush,
  output logic [2*DATA_W-1:0]   m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tlast,
`ifdef AXIS_FRAMER_TUSER_EN
  output logic                  m00_axis_tuser,
`endif
  output logic [15:0]           frame_cnt
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  framer_state_t    state;
  framer_state_t    state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             beat_valid;
  logic             beat_last;
  logic [DATA_W-1:0] beat_re;
  logic             buf_tready;
  logic             buf_tready_next;
  logic             enq;

  // While padding, a zero beat is offered every cycle; the input port is closed.
  assign beat_valid = (state == PAD) ? ENABLE : (s00_axis_tvalid & s00_axis_tready);
  assign beat_re    = (state == PAD) ? '0 : s00_axis_tdata;
  assign enq        = beat_valid & buf_tready;
  assign beat_last  = (idx == LAST_IDX);
  assign idx_next   = enq ? idx + 1'b1 : idx;

  always_comb begin
    state_next = state;
    case (state)
      RUN: if (flush && (idx_next != '0)) state_next = PAD;
      PAD: if (enq && beat_last) state_next = RUN;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (s00_axis_aresetn == RESET_ENABLE_) begin
      state           <= RUN;
      idx             <= '0;
      frame_cnt       <= '0;
      s00_axis_tready <= DISABLE;
    end else begin
      state           <= state_next;
      idx             <= idx_next;
      // Ready is computed from next-cycle buffer state so it is a clean flop output.
      s00_axis_tready <= (state_next == RUN) & buf_tready_next;
      if (enq && beat_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  axis_skid_buf #(
    .DATA_W (2 * DATA_W)
  ) u_skid_buf (
    .clk           (s00_axis_aclk),
    .rst_n         (s00_axis_aresetn),
    .s_tdata       ({{DATA_W{1'b0}}, beat_re}),
    .s_tlast       (beat_last),
`ifdef AXIS_FRAMER_TUSER_EN
    .s_tuser       (idx == '0),
`endif
    .s_tvalid      (beat_valid),
    .s_tready      (buf_tready),
    .s_tready_next (buf_tready_next),
    .m_tdata       (m00_axis_tdata),
    .m_tlast       (m00_axis_tlast),
`ifdef AXIS_FRAMER_TUSER_EN
    .m_tuser       (m00_axis_tuser),
`endif
    .m_tvalid      (m00_axis_tvalid),
    .m_tready      (m00_axis_tready)
  );

endmodule

// File: tb/tb_axis_complex_framer.sv
// tb/tb_axis_complex_framer.sv - scoreboard bench for axis_complex_framer (FRAME_LEN=8)
module tb_axis_complex_framer;

  localparam int FL = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          flush = 1'b0;
  logic [2*DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [15:0]   frame_cnt;
`ifdef AXIS_FRAMER_TUSER_EN
  logic          m_tuser;
`endif

  always #5 clk = ~clk;

  axis_complex_framer #(
    .FRAME_LEN (FL),
    .DATA_W    (DW)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .flush            (flush),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tlast   (m_tlast),
`ifdef AXIS_FRAMER_TUSER_EN
    .m00_axis_tuser   (m_tuser),
`endif
    .frame_cnt        (frame_cnt)
  );

  typedef struct {
    logic [DW-1:0] re;
    logic          last;
    logic          user;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;
  int   frames_model = 0;
  int   cyc = 0;
  logic rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: every accepted sample or pad beat occupies the next frame position.
  function automatic void push_beat(input logic [DW-1:0] re);
    exp_t e;
    e.re   = re;
    e.last = (pos == FL - 1);
    e.user = (pos == 0);
    exp_q.push_back(e);
    if (e.last) frames_model++;
    pos = (pos + 1) % FL;
  endfunction

  function automatic void model_flush();
    while (pos != 0) push_beat('0);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  logic            held_v = 1'b0;
  logic [2*DW-1:0] held_d;
  logic            held_l;
  exp_t            mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("stall_valid", 64'(m_tvalid), 64'd1);
          chk("stall_data", m_tdata, held_d);
          chk("stall_last", 64'(m_tlast), 64'(held_l));
        end
        held_v = 1'b0;
        if (m_tvalid) begin
          if (m_tready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat actual=%h expected=none", m_tdata);
            end else begin
              mon_e = exp_q.pop_front();
              chk("beat_data", m_tdata, {32'h0, mon_e.re});
              chk("beat_last", 64'(m_tlast), 64'(mon_e.last));
`ifdef AXIS_FRAMER_TUSER_EN
              chk("beat_user", 64'(m_tuser), 64'(mon_e.user));
`endif
              pop_cyc_q.push_back(cyc);
            end
          end else begin
            held_v = 1'b1;
            held_d = m_tdata;
            held_l = m_tlast;
          end
        end
      end
    end
  end

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f, output logic acc);
    s_tvalid = v;
    s_tdata  = d;
    flush    = f;
    @(negedge clk);
    acc = v && s_tready;
    if (acc) push_beat(d);
    if (f) model_flush();
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      cycle(1'b1, d, 1'b0, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!s_tready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(s_tready), 64'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  logic acc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset_m_tlast", 64'(m_tlast), 64'd0);
    chk("reset_s_tready", 64'(s_tready), 64'd0);
    chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_reset", 64'(s_tready), 64'd1);

    // Continuous 1..16 at full throughput
    pop_cyc_q.delete();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, DW'(i), 1'b0, acc);
      chk("p1_accept", 64'(acc), 64'd1);
      if (i == 1) chk("p1_latency", 64'(m_tvalid), 64'd1);
    end
    drain("p1_drain");
    chk("p1_beats", 64'(pop_cyc_q.size()), 64'd16);
    if (pop_cyc_q.size() == 16) chk("p1_no_bubble", 64'(pop_cyc_q[15] - pop_cyc_q[0]), 64'd15);
    chk("p1_frame_cnt", 64'(frame_cnt), 64'd2);

    // Partial frame then flush: zero padding to frame end
    for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i), 1'b0, acc);
    cycle(1'b0, '0, 1'b1, acc);
    chk("p2_pad_tready", 64'(s_tready), 64'd0);
    wait_ready("p2_ready_back");
    drain("p2_drain");
    chk("p2_frame_cnt", 64'(frame_cnt), 64'd3);

    // Flush coinciding with the final sample, then idle flush at index 0
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(100 + i), (i == 8), acc);
      chk("p3_accept", 64'(acc), 64'd1);
    end
    chk("p3_no_pad_tready", 64'(s_tready), 64'd1);
    cycle(1'b0, '0, 1'b1, acc);
    chk("p3_idle_flush_tready", 64'(s_tready), 64'd1);
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(200 + i), 1'b0, acc);
    drain("p3_drain");
    chk("p3_frame_cnt", 64'(frame_cnt), 64'd5);

    // Random downstream backpressure, sequential data 0..999
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) send_sample(DW'(i));
    drain("p4_drain");
    chk("p4_frame_cnt", 64'(frame_cnt), 64'(16'(frames_model)));

    // Random data, gaps and flushes under backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), DW'($urandom),
            (s_tready && ($urandom_range(0, 15) == 0)), acc);
    end
    drain("p5_drain");
    chk("p5_frame_cnt", 64'(frame_cnt), 64'(16'(frames_model)));
    rand_rdy = 1'b0;
    rdy_fixed = 1'b1;

    // Reset in the middle of a frame with a beat held in the buffer
    wait_ready("p6_ready_pre");
    cycle(1'b0, '0, 1'b1, acc);
    wait_ready("p6_ready_aligned");
    drain("p6_drain_pre");
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(300 + i), 1'b0, acc);
    drain("p6_drain_four");
    rdy_fixed = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, DW'(305), 1'b0, acc);
    chk("p6_pre_reset_tvalid", 64'(m_tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("p6_reset_tvalid", 64'(m_tvalid), 64'd0);
    chk("p6_reset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("p6_reset_tready", 64'(s_tready), 64'd0);
    exp_q.delete();
    pos = 0;
    frames_model = 0;
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    rst_n = 1'b1;
    wait_ready("p6_ready_post");
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(400 + i), 1'b0, acc);
    drain("p6_drain_post");
    chk("p6_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
